// File: rtl/mdio_master.sv
// mdio_master: MDIO management-station engine (IEEE 802.3 clause 22).
// Generates MDC and serialises read/write frames onto the MDIO pad signals.
// For reads it releases the line at turnaround and captures the PHY's data.
//
// Parameters
//   DIV           MDC half-period in clk cycles (>= 2); MDC period = 2*DIV
//   PREAMBLE_LEN  number of leading 1 bits before ST (0..32, 0 = suppressed)
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   mdc           management clock to the PHY (held low when idle)
//   mdo           serial data towards the MDIO pad (1 when not driving)
//   mdo_valid     pad output enable, 1 = station drives MDIO
//   mdi           raw, asynchronous MDIO pad input
//   cmd_*         single-command valid/ready request (write/read, PHY, reg, data)
//   resp_valid    one-cycle pulse at frame completion
//   resp_data     read data (only reads update it)
//   resp_err      read turnaround error (0 for writes)

module mdio_master #(
  parameter int DIV          = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mdc,
  output logic        mdo,
  output logic        mdo_valid,
  input  logic        mdi,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err
);

  localparam int CW = $clog2(2 * DIV);

  // Phase within one MDC period: mdc is low for phases 0..DIV-1 and high for
  // DIV..2*DIV-1. The register update at the end of PH_RISE raises mdc, the
  // cycle with phase PH_SAMP is the first one with mdc high (read sampling),
  // and the end of PH_LAST drops mdc and presents the next bit.
  localparam logic [CW-1:0] PH_RISE  = CW'(DIV - 1);
  localparam logic [CW-1:0] PH_SAMP  = CW'(DIV);
  localparam logic [CW-1:0] PH_LAST  = CW'(2 * DIV - 1);
  localparam logic [5:0]    PRE_LAST = 6'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_FRAME,
    ST_TA,
    ST_DATA
  } state_t;

  state_t          state;
  logic [CW-1:0]   phase;
  logic [5:0]      bit_cnt;
  logic [31:0]     shreg;
  logic            wr_q;
  logic            mdi_sync_p0;
  logic            mdi_sync_p1;

  // Everything after the preamble as one 32-bit word, MSB first. For reads the
  // TA and DATA positions hold ones so mdo rests at 1 while the line is released.
  function automatic logic [31:0] build_frame(input logic        wr,
                                              input logic [4:0]  phy,
                                              input logic [4:0]  rg,
                                              input logic [15:0] d);
    return {2'b01, (wr ? 2'b01 : 2'b10), phy, rg, (wr ? 2'b10 : 2'b11),
            (wr ? d : 16'hFFFF)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= '0;
      bit_cnt     <= '0;
      shreg       <= '1;
      wr_q        <= 1'b0;
      mdi_sync_p0 <= 1'b1;
      mdi_sync_p1 <= 1'b1;
      mdc         <= 1'b0;
      mdo         <= 1'b1;
      mdo_valid   <= 1'b0;
      cmd_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      // stage boundary: two-flop synchroniser for the asynchronous pad input
      mdi_sync_p0 <= mdi;
      mdi_sync_p1 <= mdi_sync_p0;
      resp_valid  <= 1'b0;

      case (state)
        ST_IDLE: begin
          mdc       <= 1'b0;
          mdo       <= 1'b1;
          mdo_valid <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            shreg     <= build_frame(cmd_write, cmd_phyad, cmd_regad, cmd_data);
            wr_q      <= cmd_write;
            phase     <= '0;
            bit_cnt   <= '0;
            mdo_valid <= 1'b1;
            cmd_ready <= 1'b0;
            resp_err  <= 1'b0;
            if (PREAMBLE_LEN == 0) begin
              state <= ST_FRAME;
              mdo   <= 1'b0;  // first ST bit
            end else begin
              state <= ST_PRE;
              mdo   <= 1'b1;
            end
          end
        end

        default: begin
          if (phase == PH_RISE) begin
            mdc <= 1'b1;
          end

          // Read capture in the first mdc-high cycle of each bit.
          if (phase == PH_SAMP && !wr_q) begin
            if (state == ST_TA && bit_cnt == 6'd1) begin
              resp_err <= mdi_sync_p1;
            end
            if (state == ST_DATA) begin
              resp_data <= {resp_data[14:0], mdi_sync_p1};
            end
          end

          if (phase == PH_LAST) begin
            phase   <= '0;
            mdc     <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            case (state)
              ST_PRE: begin
                if (bit_cnt == PRE_LAST) begin
                  state   <= ST_FRAME;
                  bit_cnt <= '0;
                  mdo     <= shreg[31];
                end
              end
              ST_FRAME: begin
                shreg <= {shreg[30:0], 1'b1};
                mdo   <= shreg[30];
                if (bit_cnt == 6'd13) begin
                  state   <= ST_TA;
                  bit_cnt <= '0;
                  // Reads hand the line to the PHY for TA and DATA.
                  if (!wr_q) begin
                    mdo_valid <= 1'b0;
                  end
                end
              end
              ST_TA: begin
                shreg <= {shreg[30:0], 1'b1};
                mdo   <= shreg[30];
                if (bit_cnt == 6'd1) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                end
              end
              ST_DATA: begin
                if (bit_cnt == 6'd15) begin
                  state      <= ST_IDLE;
                  bit_cnt    <= '0;
                  mdo        <= 1'b1;
                  mdo_valid  <= 1'b0;
                  cmd_ready  <= 1'b1;
                  resp_valid <= 1'b1;
                end else begin
                  shreg <= {shreg[30:0], 1'b1};
                  mdo   <= shreg[30];
                end
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end else begin
            phase <= phase + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
